// File: rtl/xor_descrambler_pkg.sv
// rtl/xor_descrambler_pkg.sv - shared constants, state type and seed helper for the descrambler
package xor_descrambler_pkg;

  localparam logic [31:0] LFSR_POLY    = 32'h80200003;
  localparam logic [31:0] LFSR_DEFAULT = 32'h00000001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // An all-zero seed would lock the LFSR at zero, so it is mapped to the default.
  function automatic logic [31:0] seed_to_lfsr(input logic [31:0] s);
    return (s == 32'h0) ? LFSR_DEFAULT : s;
  endfunction

endpackage

// File: rtl/lfsr32_step.sv
// rtl/lfsr32_step.sv - one Galois step of the 32-bit keystream LFSR
import xor_descrambler_pkg::*;

module lfsr32_step (
  input  logic [31:0] cur,
  output logic [31:0] nxt
);

  // Shift right; when the bit falling out is 1, fold the feedback polynomial back in.
  assign nxt = {1'b0, cur[31:1]} ^ ({32{cur[0]}} & LFSR_POLY);

endmodule

// File: rtl/xor32.sv
// rtl/xor32.sv - 32-bit bitwise XOR unit
module xor32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_descrambler.sv
// rtl/xor_descrambler.sv - single-entry XOR descrambler driven by a seeded Galois LFSR
import xor_descrambler_pkg::*;

module xor_descrambler (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] word_cnt,
  output logic        running
);

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] plain_data;
  logic        accept;

  assign running = (state == ST_RUN);

  // A seed load takes priority, so it blocks acceptance in the same cycle.
  assign in_ready = running && !seed_valid && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  lfsr32_step u_step (
    .cur (lfsr),
    .nxt (lfsr_next)
  );

  xor32 u_xor (
    .a (in_data),
    .b (lfsr),
    .y (plain_data)
  );

  // State, keystream, output register and word counter; seed load beats accept beats drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lfsr      <= LFSR_DEFAULT;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      word_cnt  <= 16'h0;
    end else if (seed_valid) begin
      state     <= ST_RUN;
      lfsr      <= seed_to_lfsr(seed);
      out_valid <= 1'b0;
      word_cnt  <= 16'h0;
    end else if (accept) begin
      out_data  <= plain_data;
      out_valid <= 1'b1;
      lfsr      <= lfsr_next;
      word_cnt  <= word_cnt + 16'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// tb/tb_xor_descrambler.sv - table, corner-case and randomized checks of xor_descrambler
module tb_xor_descrambler;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_valid;
  logic [31:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] word_cnt;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xor_descrambler dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_cnt   (word_cnt),
    .running    (running)
  );

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [15:0] e_cnt;
    logic        e_run;
  } vec_t;

  vec_t vecs [0:14];

  logic [31:0] ks [0:4095];
  logic [31:0] exp_q [$];
  logic        m_run;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    return (x >> 1) ^ ((x % 2 == 1) ? 32'h80200003 : 32'h0);
  endfunction

  task automatic fill_keystream(input logic [31:0] s);
    logic [31:0] k;
    k = (s == 0) ? 32'h1 : s;
    for (int i = 0; i < 4096; i++) begin
      ks[i] = k;
      k = ref_step(k);
    end
  endtask

  task automatic idle_inputs();
    seed_valid = 1'b0;
    seed       = 32'h0;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    out_ready  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_word_cnt", {16'h0, word_cnt}, 32'h0);
    chk("reset_running", {31'h0, running}, 32'h0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs[0]  = '{1'b0, 32'h0,        1'b1, 32'h5,        1'b1, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0};
    vecs[1]  = '{1'b1, 32'h1,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        16'd0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 32'h1,        16'd1, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h7FDFFFFC, 16'd2, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC0300002, 16'd3, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hC0300002, 16'd3, 1'b1};
    vecs[6]  = '{1'b1, 32'h0,        1'b1, 32'hAAAA,     1'b1, 1'b0, 1'b0, 32'hC0300002, 16'd0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 32'h1,        16'd1, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 32'hDEAD,     1'b0, 1'b0, 1'b1, 32'h1,        16'd1, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 32'hDEAD,     1'b0, 1'b0, 1'b1, 32'h1,        16'd1, 1'b1};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 32'hDEAD,     1'b0, 1'b0, 1'b1, 32'h1,        16'd1, 1'b1};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 32'h80200003, 16'd2, 1'b1};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h80200003, 16'd2, 1'b1};
    vecs[13] = '{1'b1, 32'h12345678, 1'b1, 32'hFFFF,     1'b0, 1'b0, 1'b0, 32'h80200003, 16'd0, 1'b1};
    vecs[14] = '{1'b0, 32'h0,        1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h0,        16'd1, 1'b1};

    for (int i = 0; i < 15; i++) begin
      seed_valid = vecs[i].sv;
      seed       = vecs[i].sd;
      in_valid   = vecs[i].iv;
      in_data    = vecs[i].din;
      out_ready  = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].e_ir});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_ov});
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
      chk($sformatf("vec%0d_word_cnt", i), {16'h0, word_cnt}, {16'h0, vecs[i].e_cnt});
      chk($sformatf("vec%0d_running", i), {31'h0, running}, {31'h0, vecs[i].e_run});
      @(negedge clk);
    end

    // Counter wrap: seed, then stream 65536 words at full rate.
    idle_inputs();
    seed_valid = 1'b1;
    seed       = 32'h5;
    @(negedge clk);
    idle_inputs();
    in_valid  = 1'b1;
    in_data   = 32'h0;
    out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_cnt_ffff", {16'h0, word_cnt}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    chk("wrap_cnt_zero", {16'h0, word_cnt}, 32'h0);
    chk("wrap_out_valid", {31'h0, out_valid}, 32'h1);
    chk("wrap_running", {31'h0, running}, 32'h1);

    // Asynchronous reset in the middle of a stalled stream.
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_running", {31'h0, running}, 32'h0);
    chk("midrst_word_cnt", {16'h0, word_cnt}, 32'h0);
    chk("midrst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3C3C3C3C;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("postrst_in_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk);
      #1;
      chk("postrst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("postrst_word_cnt", {16'h0, word_cnt}, 32'h0);
      @(negedge clk);
    end

    // Randomized traffic against a keystream-indexed reference.
    m_run = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic e_ir;
      chk("rnd_out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
      if (exp_q.size() != 0) chk("rnd_out_data", out_data, exp_q[0]);
      chk("rnd_word_cnt", {16'h0, word_cnt}, m_cnt % 65536);
      chk("rnd_running", {31'h0, running}, {31'h0, m_run});

      seed_valid = ($urandom_range(0, 99) < 2) || (c == 5);
      seed       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = $urandom;
      out_ready  = ($urandom_range(0, 9) < 6);
      #1;
      e_ir = m_run && !seed_valid && ((exp_q.size() == 0) || out_ready);
      chk("rnd_in_ready", {31'h0, in_ready}, {31'h0, e_ir});

      if (seed_valid) begin
        m_run = 1'b1;
        m_cnt = 0;
        exp_q.delete();
        fill_keystream(seed);
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && e_ir) begin
          exp_q.push_back(in_data ^ ks[m_cnt]);
          m_cnt++;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_descrambler.md
XOR_DESCRAMBLER -- requirements
Module: xor_descrambler

Interface
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 rst  input  1  Reset, asynchronous, active-high.
REQ-003 seed_valid  input  1  One-cycle pulse that loads a new keystream seed.
REQ-004 seed  input  32  Keystream seed, sampled when seed_valid=1.
REQ-005 in_valid  input  1  Scrambled input word is present.
REQ-006 in_ready  output  1  Block accepts the input word this cycle.
REQ-007 in_data  input  32  Scrambled word.
REQ-008 out_valid  output  1  Descrambled word is held in the output register.
REQ-009 out_ready  input  1  Consumer takes the output word this cycle.
REQ-010 out_data  output  32  Descrambled word.
REQ-011 word_cnt  output  16  Number of words accepted since the last seed load; wraps modulo 2^16.
REQ-012 running  output  1  1 when the state is RUN.

Function
REQ-013 The block SHALL have two states: IDLE (no seed loaded) and RUN.
REQ-014 Transitions: IDLE->RUN on seed_valid; RUN->RUN on seed_valid (reseed); no other transitions except reset.
REQ-015 Seed load: lfsr <= (seed==0) ? 32'h00000001 : seed; out_valid <= 0; word_cnt <= 0.
REQ-016 in_ready SHALL equal running && !seed_valid && (!out_valid || out_ready), combinationally.
REQ-017 Accept (in_valid && in_ready): out_data <= in_data XOR lfsr; out_valid <= 1; lfsr <= step(lfsr); word_cnt <= word_cnt+1.
REQ-018 step(x) SHALL be {1'b0, x[31:1]} XOR (x[0] ? 32'h80200003 : 0); this is one Galois step per accepted word.
REQ-019 Latency: one cycle from input accept to out_valid; throughput is one word per cycle when out_ready is held at 1.
REQ-020 Output drain: out_valid && out_ready && no accept -> out_valid <= 0.
REQ-021 Back-pressure: while out_valid=1 and out_ready=0, out_data, lfsr and word_cnt SHALL hold.
REQ-022 Simultaneous seed_valid and in_valid: the seed wins, the input is not accepted, and any pending output word is discarded.
REQ-023 In IDLE, in_ready=0 and out_valid=0 regardless of the other inputs.
REQ-024 word_cnt at 16'hFFFF plus one accept -> 16'h0000; there is no other side effect.

Reset
REQ-025 On rst=1 the block SHALL asynchronously enter IDLE with lfsr=32'h00000001, out_valid=0, out_data=0 and word_cnt=0.
REQ-026 Reset mid-stream SHALL drop the pending word; after reset release the block requires a fresh seed before it accepts data.

Structure
REQ-027 A shared package SHALL hold LFSR_POLY=32'h80200003, LFSR_DEFAULT=32'h00000001 and the IDLE/RUN state enum.
REQ-028 A combinational sub-module lfsr32_step SHALL implement step(); the data XOR SHALL use the team's 32-bit bitwise XOR unit.
REQ-029 The data path SHALL be registered at the output only; there is no other buffering (single-entry).

Verification
REQ-030 Seed 0x00000001, then in_data 0x00000000 with out_ready=1 -> next cycle out_data=0x00000001 and word_cnt=1.
REQ-031 Continue with in_data 0xFFFFFFFF -> out_data=0x7FDFFFFC; the next keystream word is 0xC0300002.
REQ-032 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and out_data and word_cnt are stable; on release the stream resumes with no loss or duplication.
REQ-033 seed_valid and in_valid in the same cycle with a pending output -> out_valid=0, word_cnt=0, and the input is not consumed.
REQ-034 Seed 0x00000000 -> behaves identically to seed 0x00000001; in_valid while in IDLE -> in_ready=0.
REQ-035 Assert rst mid-stream -> immediately IDLE, out_valid=0; after release, data is ignored until a seed is loaded; 65536 accepts wrap word_cnt to 0.
